// File: rtl/mips_wait_memory.sv
// Unified instruction/data memory for the multi-cycle MIPS: fixed-latency access with a ready pulse and error reporting.
// Optional MEM_BYTE_EN_EN adds byte_en for partial-word writes.
module mips_wait_memory #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH      = 1024,
  parameter int LATENCY    = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_WIDTH-1:0]   address,
  input  logic [DATA_WIDTH-1:0]   write_data,
  input  logic                    mem_read,
  input  logic                    mem_write,
`ifdef MEM_BYTE_EN_EN
  input  logic [DATA_WIDTH/8-1:0] byte_en,
`endif
  output logic [DATA_WIDTH-1:0]   read_data,
  output logic                    ready,
  output logic                    busy,
  output logic                    err
);

  localparam int IW = $clog2(DEPTH);
  localparam int NB = DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } state_t;

  state_t state, nxt;

  logic [3:0]            cnt;
  logic [IW-1:0]         idx_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  wr_q;
  logic                  err_q;
  logic [NB-1:0]         be_q;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic req;
  logic bad;
  logic fire;

  assign req  = mem_read | mem_write;
  // Out of range means any address bit above the word index is set.
  assign bad  = (address[1:0] != 2'b00)
              | ((address >> (IW + 2)) != '0)
              | (mem_read & mem_write);
  assign fire = (state == WAIT) && (cnt == 4'd0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    if (req) nxt = WAIT;
      WAIT:    if (cnt == 4'd0) nxt = DONE;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt       <= '0;
      idx_q     <= '0;
      wdata_q   <= '0;
      wr_q      <= 1'b0;
      err_q     <= 1'b0;
      read_data <= '0;
    end else begin
      if (state == IDLE && req) begin
        cnt     <= 4'(LATENCY - 1);
        idx_q   <= address[IW+1:2];
        wdata_q <= write_data;
        wr_q    <= mem_write;
        err_q   <= bad;
      end else if (state == WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (fire && !wr_q && !err_q) read_data <= mem[idx_q];
    end
  end

`ifdef MEM_BYTE_EN_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                      be_q <= '0;
    else if (state == IDLE && req) be_q <= byte_en;
  end
`else
  assign be_q = '1;
`endif

  // Array has no reset; an aborted access never reaches fire.
  always_ff @(posedge clk) begin
    if (fire && wr_q && !err_q) begin
      for (int b = 0; b < NB; b++) begin
        if (be_q[b]) mem[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
      end
    end
  end

  assign ready = (state == DONE);
  assign busy  = (state == WAIT);
  assign err   = ready & err_q;

endmodule

// File: tb/tb_mips_wait_memory.sv
// Scoreboard bench for mips_wait_memory: random and directed accesses
// against an array model of the memory.
module tb_mips_wait_memory;

  parameter int LAT = 2;
  localparam int DW    = 32;
  localparam int AW    = 32;
  localparam int DEPTH = 1024;

  typedef struct {
    logic [DW-1:0] data;
    logic          err;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [AW-1:0] address = '0;
  logic [DW-1:0] write_data = '0;
  logic          mem_read = 1'b0;
  logic          mem_write = 1'b0;
  logic [3:0]    byte_en = 4'hF;
  logic [DW-1:0] read_data;
  logic          ready;
  logic          busy;
  logic          err;

  int vectors = 0;
  int miscompares = 0;
  int ready_cnt = 0;

  exp_t          exp_q[$];
  logic [DW-1:0] model_mem [int];
  logic [DW-1:0] last_rd = '0;

  int pool[12] = '{0, 1, 2, 3, 4, 8, 16, 20, 100, 511, 512, 1023};

  mips_wait_memory #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .DEPTH(DEPTH),
    .LATENCY(LAT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .address(address),
    .write_data(write_data),
    .mem_read(mem_read),
    .mem_write(mem_write),
`ifdef MEM_BYTE_EN_EN
    .byte_en(byte_en),
`endif
    .read_data(read_data),
    .ready(ready),
    .busy(busy),
    .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got,
                       input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference: memory as a word array keyed by index.
  function automatic exp_t model(input logic rd, input logic wr,
                                 input logic [AW-1:0] addr,
                                 input logic [DW-1:0] data,
                                 input logic [3:0] be);
    exp_t e;
    int   idx;
    logic [DW-1:0] w;
    idx   = int'(addr / 4) % DEPTH;
    e.err = (addr % 4 != 0) || (addr >= 4 * DEPTH) || (rd && wr);
    if (!e.err && wr) begin
      w = model_mem.exists(idx) ? model_mem[idx] : '0;
      for (int b = 0; b < 4; b++)
        if (be[b]) w[8*b +: 8] = data[8*b +: 8];
      model_mem[idx] = w;
    end else if (!e.err) begin
      last_rd = model_mem[idx];
    end
    e.data = last_rd;
    return e;
  endfunction

  always @(negedge clk) begin
    if (rst && ready) begin
      ready_cnt++;
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL spurious_ready: got ready=1 expected no access pending");
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("read_data", 64'(read_data), 64'(e.data));
        check("err", 64'(err), 64'(e.err));
        check("busy_at_ready", 64'(busy), 64'd0);
      end
    end else if (rst && err) begin
      check("err_idle", 64'(err), 64'd0);
    end
  end

  task automatic do_access(input logic rd, input logic wr,
                           input logic [AW-1:0] addr,
                           input logic [DW-1:0] data,
                           input logic [3:0] be);
    int cyc;
    exp_q.push_back(model(rd, wr, addr, data, be));
    mem_read   = rd;
    mem_write  = wr;
    address    = addr;
    write_data = data;
    byte_en    = be;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!ready && cyc < 20);
    check("latency", 64'(cyc), 64'(LAT + 1));
    mem_read  = 1'b0;
    mem_write = 1'b0;
    @(negedge clk);
  endtask

  task automatic hold_read(input logic [AW-1:0] addr);
    int hits[$];
    for (int i = 0; i < 3; i++)
      exp_q.push_back(model(1'b1, 1'b0, addr, '0, 4'hF));
    mem_read = 1'b1;
    address  = addr;
    for (int n = 1; n <= 3 * LAT + 6; n++) begin
      @(negedge clk);
      if (ready) hits.push_back(n);
    end
    mem_read = 1'b0;
    check("hold_count", 64'(hits.size()), 64'd3);
    if (hits.size() == 3) begin
      check("hold_gap1", 64'(hits[1] - hits[0]), 64'(LAT + 2));
      check("hold_gap2", 64'(hits[2] - hits[1]), 64'(LAT + 2));
    end
    @(negedge clk);
  endtask

  initial begin
    int rc;
    int k;
    logic [AW-1:0] a;
    logic [3:0] be;

    repeat (3) @(negedge clk);
    check("rst_read_data", 64'(read_data), 64'd0);
    check("rst_ready", 64'(ready), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    rst = 1'b1;
    @(negedge clk);

    foreach (pool[i])
      do_access(1'b0, 1'b1, AW'(pool[i] * 4), DW'($urandom), 4'hF);

    do_access(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
    do_access(1'b1, 1'b0, 32'h10, '0, 4'hF);
    do_access(1'b1, 1'b0, 32'h13, '0, 4'hF);
    do_access(1'b1, 1'b0, 32'h1000, '0, 4'hF);
    do_access(1'b0, 1'b1, 32'h1000, 32'h0BADF00D, 4'hF);
    do_access(1'b1, 1'b0, 32'h0, '0, 4'hF);
    do_access(1'b1, 1'b1, 32'h20, 32'h55555555, 4'hF);
    do_access(1'b1, 1'b0, 32'h20, '0, 4'hF);
    hold_read(32'h20);

    // Abort a write one cycle after acceptance.
    mem_write  = 1'b1;
    address    = 32'h40;
    write_data = 32'h12345678;
    @(negedge clk);
    @(negedge clk);
    rst       = 1'b0;
    mem_write = 1'b0;
    last_rd   = '0;
    @(negedge clk);
    check("abort_rd_zero", 64'(read_data), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    rc  = ready_cnt;
    rst = 1'b1;
    repeat (LAT + 4) @(negedge clk);
    check("abort_no_ready", 64'(ready_cnt), 64'(rc));
    do_access(1'b1, 1'b0, 32'h40, '0, 4'hF);

`ifdef MEM_BYTE_EN_EN
    do_access(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
    do_access(1'b0, 1'b1, 32'h10, 32'hAABBCCDD, 4'b0101);
    do_access(1'b1, 1'b0, 32'h10, '0, 4'hF);
    check("byte_en_word", 64'(read_data), 64'hDEBBBEDD);
    do_access(1'b0, 1'b1, 32'h10, 32'h11111111, 4'b0000);
    do_access(1'b1, 1'b0, 32'h10, '0, 4'hF);
`endif

    for (int n = 0; n < 80; n++) begin
      k  = $urandom_range(0, 9);
      a  = AW'(pool[$urandom_range(0, 11)] * 4);
      be = 4'hF;
`ifdef MEM_BYTE_EN_EN
      be = 4'($urandom);
`endif
      if (k <= 3)      do_access(1'b1, 1'b0, a, '0, be);
      else if (k <= 6) do_access(1'b0, 1'b1, a, DW'($urandom), be);
      else if (k == 7) do_access(k[0], ~k[0], a | AW'($urandom_range(1, 3)), DW'($urandom), be);
      else if (k == 8) do_access(1'b1, 1'b0, a + AW'(4 * DEPTH * $urandom_range(1, 7)), '0, be);
      else             do_access(1'b1, 1'b1, a, DW'($urandom), be);
    end

    repeat (LAT + 4) @(negedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mips_wait_memory.md
Name: mips_wait_memory

Overview:
- Parametrised unified instruction/data memory for the multi-cycle MIPS.
- Successor to the zero-wait memory. Adds configurable access latency, a one-cycle `ready` completion handshake, and error reporting for misaligned and out-of-range accesses.
- Sits between the processor's `address`/`mem_out`/`mem_read`/`mem_write` outputs and its `mem_in` input.
- The processor stalls in its memory states until `ready`.

Parameters:
- DATA_WIDTH, 32, word width in bits; must be a multiple of 8.
- ADDR_WIDTH, 32, byte-address width.
- DEPTH, 1024, number of words; power of 2.
- LATENCY, 2, cycles from request acceptance to `ready`; legal range 1..15.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset (0 = reset).
- address  input  ADDR_WIDTH  byte address; word index = address[log2(DEPTH)+1:2].
- write_data  input  DATA_WIDTH  write data.
- mem_read  input  1  read request; held until `ready`.
- mem_write  input  1  write request; held until `ready`.
- read_data  output  DATA_WIDTH  read result.
- ready  output  1  one-cycle completion pulse.
- busy  output  1  access in progress.
- err  output  1  error flag, valid with `ready`.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, read_data=0, ready=0, busy=0, err=0, latency counter=0.
  - Memory array is not cleared.
  - Reset asserted mid-access aborts the access: no array write occurs, and no `ready` is issued after release.
- FSM states: IDLE, WAIT, DONE.
- IDLE:
  - When mem_read|mem_write=1 at a rising edge, the request is accepted.
  - On acceptance: latch address, write_data, op and error class; counter=LATENCY-1; busy=1; go to WAIT.
  - Inputs are not re-sampled until the next IDLE.
- WAIT:
  - Counter decrements each edge.
  - At the edge where counter==0: perform the access, go to DONE.
  - LATENCY=1 passes through WAIT for exactly one edge.
- DONE:
  - ready=1 and busy=0 for exactly one cycle; then IDLE.
  - A request still high in the cycle after DONE is a new access.
- Timing: request accepted at edge k; array updated and read_data loaded at edge k+LATENCY; ready high during cycle k+LATENCY..k+LATENCY+1. Back-to-back accesses cost LATENCY+2 cycles each.
- Read:
  - read_data = array[index].
  - read_data holds its value until the next completed read; writes and errors do not change it.
- Write: array[index] = write_data at the completion edge.
- Error cases (err=1 with the ready pulse, no array write, read_data unchanged):
  - address[1:0] != 0 (misaligned).
  - address >= 4*DEPTH (upper bits nonzero).
  - mem_read and mem_write both 1 at acceptance.
- err=0 in all other cycles.
- Request dropped before `ready`: ignored; the access completes normally using the latched values.

Optional Feature:
- MEM_BYTE_EN_EN defined:
  - Adds input `byte_en` [DATA_WIDTH/8-1:0].
  - Writes update only the enabled bytes.
  - A write with byte_en=0 completes with ready, err=0, and no change to the array.
  - Reads ignore byte_en.
- Undefined: port absent; all writes are full-word.

Test Plan:
- rst=0 then release; write 0xDEADBEEF to address 0x10 with LATENCY=2 → ready exactly 2 cycles after acceptance, err=0; a following read of 0x10 returns 0xDEADBEEF with the ready pulse.
- Read address 0x13 (misaligned) → ready with err=1; read_data keeps the prior 0xDEADBEEF.
- Read at 4*DEPTH (0x1000 for DEPTH=1024) → err=1; a write to 0x1000 leaves word 0 unchanged.
- mem_read=mem_write=1 at address 0x20 → err=1, word 8 unchanged. Then hold mem_read high continuously → one ready per LATENCY+2 cycles.
- Assert rst=0 one cycle into a write of 0x12345678 to 0x40 → no ready after release; a later read of 0x40 returns the old contents.
- With MEM_BYTE_EN_EN: write 0xAABBCCDD to 0x10 (word holds 0xDEADBEEF) with byte_en=4'b0101 → read returns 0xDEBBBEDD. Repeat all scenarios at LATENCY=1 and LATENCY=5.
